oisc_com_uart: RTL
==================

Name: oisc_com_uart

Overview:
- Memory-mapped UART peripheral on the oisc8 communications bus. It sits directly downstream of the CPU's com block and consumes the processor_port signals com_addr, com_wr and com_rd.
- Writes to the TX data address queue bytes for serial transmission. Reads from the RX data address pop received bytes.
- Status and baud-divider registers share the same 8-bit com address space.
- Provides the CPU's only byte-serial I/O path to the host.

Parameters:
- FIFO_DEPTH, 8, entries in each of the TX and RX FIFOs; power of two, minimum 2.
- DIV_RESET, 16'd26, reset value of the baud divider (115200 baud at 50 MHz with 16x oversampling).
- ADDR_TXD, 8'h10, write-only TX data address.
- ADDR_RXD, 8'h11, read-only RX data address; a read pops the RX FIFO.
- ADDR_STAT, 8'h12, read-only status address; a read clears the sticky flags.
- ADDR_DIVLO, 8'h13, write-only divider bits [7:0].
- ADDR_DIVHI, 8'h14, write-only divider bits [15:8].

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- com_addr  in  8  com address; 8'd0 means idle. Each non-zero value is a single-cycle access.
- com_wr  in  8  write data, valid while com_addr is non-zero.
- com_rd  out  8  read data, combinational from com_addr.
- uart_rxd  in  1  serial input, asynchronous to clk.
- uart_txd  out  1  serial output, idle high.
- irq  out  1  high while the RX FIFO is non-empty or the overrun flag is set.

Behaviour:
- Reset (rst low, asynchronous):
  - uart_txd=1, irq=0.
  - Both FIFOs empty; divider=DIV_RESET; all flags 0; both FSMs in IDLE.
  - While rst is low, com_rd=0.
  - An assertion in mid-frame aborts the frame; the line returns to 1 immediately.
- Access decode: one access per clk cycle in which com_addr matches an address. Unmatched addresses are ignored and com_rd=0.
- com_rd mux:
  - RXD: RX FIFO head, or 8'h00 if empty.
  - STAT: {3'b0, ovr, frm, rx_ne, tx_full, tx_busy}.
    - tx_busy = TX FSM not IDLE or TX FIFO non-empty.
    - frm = sticky framing error.
    - ovr = sticky RX overrun.
  - All other addresses: 8'h00.
- Side effects at the clock edge:
  - RXD read with RX FIFO non-empty: pop. RXD read when empty: no pop.
  - STAT read: clears ovr and frm. A flag set in the same cycle wins, so it stays 1.
  - TXD with TX FIFO full: byte dropped, no flag.
  - DIVLO/DIVHI: update that half. The new value takes effect at the next tick reload.
- Tick generator:
  - 16-bit down-counter reloads with the divider when it reaches 0 and emits a one-cycle tick.
  - One tick per (div+1) clocks; one bit period = 16 ticks.
  - div=0 gives a tick every cycle.
- TX FSM (states IDLE, START, DATA, STOP):
  - IDLE: when the FIFO is non-empty, pop the byte into the shift register and go to START. Tick phase is aligned to the free-running generator.
  - START: drive 0 for 16 ticks.
  - DATA: 8 bits LSB first, 16 ticks each.
  - STOP: drive 1 for 16 ticks, then IDLE. Back-to-back bytes have no extra idle gap.
- RX path:
  - uart_rxd passes through a 2-flop synchroniser.
  - States IDLE, START, DATA, STOP.
  - IDLE: a falling edge moves to START.
  - START: sample at tick 8. If the sample is 1, treat it as a glitch and return to IDLE; otherwise go to DATA.
  - DATA: sample 8 bits at 16-tick spacing, LSB first.
  - STOP: sample once.
    - Sample 1: push the byte. If the FIFO is full, discard the byte and set ovr.
    - Sample 0: set frm, discard the byte, and wait in IDLE for the line to return to 1 before re-arming.
- Simultaneous RX push and CPU pop on a full FIFO: the pop occurs first, the push succeeds, and ovr is not set.
- FIFOs:
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
  - full = MSBs differ and the rest of the pointer bits are equal.
  - Simultaneous push and pop keeps the count unchanged.

Decomposition:
- Shared package oisc8_pkg:
  - typedef enum uart_state_t {IDLE, START, DATA, STOP}, used by both FSMs.
  - The default com address constants (COM_UART_TXD … COM_UART_DIVHI).
  - STAT bit index constants.
- One sub-module, uart_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty), instantiated twice.

Test Plan:
- Reset, then idle: uart_txd=1, STAT read = 8'h00, irq=0, RXD read = 8'h00.
- Divider set to 0 (DIVLO=0, DIVHI=0), then TXD write 8'hA5: 16 clocks low, then bits 1,0,1,0,0,1,0,1 at 16 clocks each, then 16 clocks high. tx_busy clears afterwards.
- div=0, nine TXD writes with FIFO_DEPTH=8: the first byte starts sending and 8 are queued. The 10th write issued while tx_full=1 is dropped. Exactly 9 frames appear on uart_txd.
- div=0, drive frame 8'h3C on uart_rxd: irq rises about 3 clocks after the stop-bit sample. STAT=8'h04, RXD read returns 8'h3C, after which irq=0 and STAT=8'h00.
- Nine RX frames sent without reads: the first 8 are stored and the 9th sets ovr. STAT=8'h14; a second STAT read returns 8'h04.
- Frame with stop bit 0: frm set, no byte stored, STAT=8'h08. A 4-clock low glitch on idle uart_rxd produces no byte and no flag. Asserting rst low mid-TX drives uart_txd to 1 asynchronously.

Source files
------------

// File: rtl/oisc8_pkg.sv
// Shared oisc8 types and constants: UART FSM states, default com map, STAT layout.
package oisc8_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam logic [7:0] COM_UART_TXD   = 8'h10;
  localparam logic [7:0] COM_UART_RXD   = 8'h11;
  localparam logic [7:0] COM_UART_STAT  = 8'h12;
  localparam logic [7:0] COM_UART_DIVLO = 8'h13;
  localparam logic [7:0] COM_UART_DIVHI = 8'h14;

  localparam int unsigned STAT_TX_BUSY = 0;
  localparam int unsigned STAT_TX_FULL = 1;
  localparam int unsigned STAT_RX_NE   = 2;
  localparam int unsigned STAT_FRM     = 3;
  localparam int unsigned STAT_OVR     = 4;

endpackage

// File: rtl/oisc_com_uart_if.sv
// oisc8 com bus: one-cycle accesses selected by a non-zero address.
interface oisc_com_uart_if;
  logic [7:0] com_addr;
  logic [7:0] com_wr;
  logic [7:0] com_rd;

  modport master (output com_addr, output com_wr, input com_rd);
  modport slave  (input com_addr, input com_wr, output com_rd);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a pop on a full FIFO frees room for a same-cycle push.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_c;
  logic             do_pop_c;

  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop_c  = pop && !empty;
  assign do_push_c = push && (!full || do_pop_c);
  assign dout      = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push_c) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop_c)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/oisc_com_uart.sv
// Memory-mapped UART on the oisc8 com bus: TX/RX FIFOs, 16x-oversampled serial FSMs, sticky status.
module oisc_com_uart
  import oisc8_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd26,
  parameter logic [7:0]  ADDR_TXD   = COM_UART_TXD,
  parameter logic [7:0]  ADDR_RXD   = COM_UART_RXD,
  parameter logic [7:0]  ADDR_STAT  = COM_UART_STAT,
  parameter logic [7:0]  ADDR_DIVLO = COM_UART_DIVLO,
  parameter logic [7:0]  ADDR_DIVHI = COM_UART_DIVHI
) (
  input  logic             clk,
  input  logic             rst,
  oisc_com_uart_if.slave   com,
  input  logic             uart_rxd,
  output logic             uart_txd,
  output logic             irq
);

  // Access decode
  logic access_c, wr_txd_c, rd_rxd_c, rd_stat_c, wr_divlo_c, wr_divhi_c;
  assign access_c   = (com.com_addr != 8'h00);
  assign wr_txd_c   = access_c && (com.com_addr == ADDR_TXD);
  assign rd_rxd_c   = access_c && (com.com_addr == ADDR_RXD);
  assign rd_stat_c  = access_c && (com.com_addr == ADDR_STAT);
  assign wr_divlo_c = access_c && (com.com_addr == ADDR_DIVLO);
  assign wr_divhi_c = access_c && (com.com_addr == ADDR_DIVHI);

  // Free-running baud tick; a new divider is picked up at the next reload.
  logic [15:0] div_q, tick_cnt_q;
  logic        tick_c;
  assign tick_c = (tick_cnt_q == 16'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q      <= DIV_RESET;
      tick_cnt_q <= DIV_RESET;
    end else begin
      if (wr_divlo_c) div_q[7:0]  <= com.com_wr;
      if (wr_divhi_c) div_q[15:8] <= com.com_wr;
      tick_cnt_q <= tick_c ? div_q : tick_cnt_q - 16'd1;
    end
  end

  // FIFOs
  logic       tx_push_c, tx_pop_c, tx_full, tx_empty;
  logic [7:0] tx_dout;
  logic       rx_push_c, rx_pop_c, rx_full, rx_empty;
  logic [7:0] rx_dout;
  logic [7:0] rx_shift_q;

  assign tx_push_c = wr_txd_c && !tx_full;
  assign rx_pop_c  = rd_rxd_c && !rx_empty;

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push_c),
    .pop   (tx_pop_c),
    .din   (com.com_wr),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push_c),
    .pop   (rx_pop_c),
    .din   (rx_shift_q),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // TX FSM
  uart_state_t tx_state_q;
  logic [3:0]  tx_tick_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_shift_q;
  logic        txd_q;
  logic        tx_last_c;

  assign tx_last_c = tick_c && (tx_tick_q == 4'd15);
  // The STOP-end pop chains the next frame without an idle gap.
  assign tx_pop_c  = !tx_empty &&
                     ((tx_state_q == IDLE) || ((tx_state_q == STOP) && tx_last_c));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= IDLE;
      tx_tick_q  <= 4'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      txd_q      <= 1'b1;
    end else begin
      if (tick_c && (tx_state_q != IDLE)) tx_tick_q <= tx_tick_q + 4'd1;
      case (tx_state_q)
        IDLE: begin
          if (tx_pop_c) begin
            tx_shift_q <= tx_dout;
            tx_tick_q  <= 4'd0;
            txd_q      <= 1'b0;
            tx_state_q <= START;
          end
        end
        START: begin
          if (tx_last_c) begin
            txd_q      <= tx_shift_q[0];
            tx_bit_q   <= 3'd0;
            tx_state_q <= DATA;
          end
        end
        DATA: begin
          if (tx_last_c) begin
            if (tx_bit_q == 3'd7) begin
              txd_q      <= 1'b1;
              tx_state_q <= STOP;
            end else begin
              txd_q      <= tx_shift_q[1];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_bit_q   <= tx_bit_q + 3'd1;
            end
          end
        end
        STOP: begin
          if (tx_last_c) begin
            if (tx_pop_c) begin
              tx_shift_q <= tx_dout;
              txd_q      <= 1'b0;
              tx_state_q <= START;
            end else begin
              tx_state_q <= IDLE;
            end
          end
        end
        default: tx_state_q <= IDLE;
      endcase
    end
  end

  // RX synchroniser and FSM; falling-edge arming keeps a stuck-low line from re-triggering.
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  uart_state_t rx_state_q;
  logic [3:0]  rx_tick_q;
  logic [2:0]  rx_bit_q;
  logic        rx_last_c, rx_stop_ok_c, rx_stop_bad_c, ovr_set_c;

  assign rx_last_c     = tick_c && (rx_tick_q == 4'd15);
  assign rx_stop_ok_c  = (rx_state_q == STOP) && rx_last_c && rx_s2_q;
  assign rx_stop_bad_c = (rx_state_q == STOP) && rx_last_c && !rx_s2_q;
  assign rx_push_c     = rx_stop_ok_c && (!rx_full || rx_pop_c);
  assign ovr_set_c     = rx_stop_ok_c && rx_full && !rx_pop_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= IDLE;
      rx_tick_q  <= 4'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
    end else begin
      rx_s1_q   <= uart_rxd;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      case (rx_state_q)
        IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_tick_q  <= 4'd0;
            rx_state_q <= START;
          end
        end
        START: begin
          if (tick_c) begin
            if (rx_tick_q == 4'd7) begin
              rx_tick_q <= 4'd0;
              rx_bit_q  <= 3'd0;
              rx_state_q <= rx_s2_q ? IDLE : DATA;
            end else begin
              rx_tick_q <= rx_tick_q + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick_c) rx_tick_q <= rx_tick_q + 4'd1;
          if (rx_last_c) begin
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= STOP;
          end
        end
        STOP: begin
          if (tick_c) rx_tick_q <= rx_tick_q + 4'd1;
          if (rx_last_c) rx_state_q <= IDLE;
        end
        default: rx_state_q <= IDLE;
      endcase
    end
  end

  // Sticky flags: a same-cycle set beats the STAT-read clear.
  logic ovr_q, frm_q, irq_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr_q <= 1'b0;
      frm_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ovr_q <= ovr_set_c | (ovr_q & ~rd_stat_c);
      frm_q <= rx_stop_bad_c | (frm_q & ~rd_stat_c);
      irq_q <= !rx_empty || ovr_q;
    end
  end

  // Read mux
  logic [7:0] stat_c;
  logic [7:0] rd_data_c;

  always_comb begin
    stat_c               = 8'h00;
    stat_c[STAT_TX_BUSY] = (tx_state_q != IDLE) || !tx_empty;
    stat_c[STAT_TX_FULL] = tx_full;
    stat_c[STAT_RX_NE]   = !rx_empty;
    stat_c[STAT_FRM]     = frm_q;
    stat_c[STAT_OVR]     = ovr_q;
  end

  always_comb begin
    rd_data_c = 8'h00;
    if (rst) begin
      if (rd_rxd_c && !rx_empty) rd_data_c = rx_dout;
      else if (rd_stat_c)        rd_data_c = stat_c;
    end
  end

  assign com.com_rd = rd_data_c;
  assign uart_txd   = txd_q;
  assign irq        = irq_q;

endmodule
